mix_columns_iter: RTL and testbench
===================================

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, number of state columns transformed per RUN cycle; legal values 1, 2 and 4 only.
REQ-002 SHALL derive localparam NSTEP = 4/COLS_PER_CYCLE, the number of RUN cycles per block.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  the in_state and in_inv inputs are valid.
REQ-006 SHALL have port in_ready  output  1  the block can accept a state.
REQ-007 SHALL have port in_state  input  128  AES state; column c = bits [32c+31:32c]; row 0 = [32c+24 +: 8], row 3 = [32c +: 8].
REQ-008 SHALL have port in_inv  input  1  0 = MixColumns, 1 = InvMixColumns.
REQ-009 SHALL have port out_valid  output  1  out_state holds a completed result.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts out_state.
REQ-011 SHALL have port out_state  output  128  transformed state, same byte layout as in_state.
REQ-012 SHALL have port busy  output  1  high in the RUN and DONE states.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE; an input transfer occurs on an edge where in_valid and in_ready are both high.
REQ-015 On an input transfer, SHALL latch in_state into a work register, latch in_inv into a mode register, clear the column counter to 0, and enter RUN.
REQ-016 In RUN, each edge SHALL transform the columns counter to counter+COLS_PER_CYCLE-1 in place, then advance the counter by COLS_PER_CYCLE.
REQ-017 On the edge that processes the final column group (counter = 4-COLS_PER_CYCLE), SHALL enter DONE instead of advancing the counter; the counter wraps to 0.
REQ-018 Forward mode, per column (a0..a3 = rows 0..3): each row r = {02,03,01,01} rotated right by r, applied over GF(2^8) with reduction polynomial 0x11B.
REQ-019 Inverse mode SHALL use the coefficients {0e,0b,0d,09}, rotated the same way.
REQ-020 SHALL hold the mode fixed for the whole block; changes on in_inv after acceptance SHALL have no effect.
REQ-021 Latency: out_valid SHALL rise NSTEP+1 edges after the accepting edge (2 edges for COLS_PER_CYCLE=4, 5 edges for COLS_PER_CYCLE=1).
REQ-022 In DONE, SHALL assert out_valid and drive out_state from the work register, stable until the transfer.
REQ-023 DONE with out_ready=1 SHALL return the block to IDLE on that edge; with out_ready=0 it SHALL stay in DONE indefinitely.
REQ-024 SHALL ignore in_valid whenever the FSM is not in IDLE; no input is queued and none is lost silently, because in_ready is low.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 SHALL contain no combinational path from in_valid or out_ready to in_ready or out_valid.
REQ-027 out_state SHALL be 0 whenever out_valid is 0.

Reset
REQ-028 rst=1 on any edge SHALL force IDLE, counter 0, work register 0, mode 0; rst has priority over every other input.
REQ-029 During and after reset: in_ready=1 (from the first edge after rst deasserts), out_valid=0, busy=0, out_state=0.
REQ-030 Reset asserted in RUN or DONE SHALL abort the block with no output transfer; the next accepted block SHALL be processed normally.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, busy=0 and out_state=0 after release; no transfer occurs.
REQ-032 Forward, every column db,13,53,45 (rows 0..3) -> every output column 8e,4d,a1,bc; out_valid after NSTEP+1 edges. A second block with columns f2,0a,22,5c / 01,01,01,01 / c6,c6,c6,c6 / d4,d4,d4,d5 -> 9f,dc,58,9d / 01,01,01,01 / c6,c6,c6,c6 / d5,d5,d7,d6.
REQ-033 Inverse: in_inv=1, every column 8e,4d,a1,bc -> every column db,13,53,45; toggle in_inv after acceptance -> result unchanged.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> out_state constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 Reset mid-RUN on the second RUN edge (COLS_PER_CYCLE=1) -> out_valid never rises; the next block produces the correct result with latency 5.
REQ-036 Run each of COLS_PER_CYCLE = 1, 2 and 4 with 1000 random states, forward then inverse -> each round trip equals the original state, and each latency is exactly NSTEP+1 edges.

Source files
------------

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine with a valid/ready handshake
// on both sides; COLS_PER_CYCLE columns are transformed in place on each RUN edge.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NSTEP = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE < 1 || COLS_PER_CYCLE > 4 || NSTEP * COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic          mode_q, mode_d;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient used is at most 4 bits, so a product is an XOR of a*1, a*2, a*4, a*8.
  function automatic logic [7:0] mulc(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [3:0]  base [4];
    logic [7:0]  a [4];
    logic [7:0]  b;
    logic [31:0] res;
    if (inv) begin
      base[0] = 4'he; base[1] = 4'hb; base[2] = 4'hd; base[3] = 4'h9;
    end else begin
      base[0] = 4'h2; base[1] = 4'h3; base[2] = 4'h1; base[3] = 4'h1;
    end
    for (int k = 0; k < 4; k++) a[k] = col[24-8*k +: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      b = '0;
      for (int k = 0; k < 4; k++) b = b ^ mulc(a[k], base[2'(k - r)]);
      res[24-8*r +: 8] = b;
    end
    return res;
  endfunction

  logic [1:0]  lane_idx [COLS_PER_CYCLE];
  logic [31:0] lane_out [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
    assign lane_idx[gi] = cnt_q + 2'(gi);
    assign lane_out[gi] = mix_col(work_q[{lane_idx[gi], 5'b0} +: 32], mode_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          mode_d  = in_inv;
          cnt_d   = 2'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[{lane_idx[k], 5'b0} +: 32] = lane_out[k];
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 2'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_STEP;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      work_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

  // Handshake outputs depend on the state register only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_state = out_valid ? work_q : '0;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle) share
// the stimulus and are checked against a GF(2^8) matrix reference model.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_ready;
  wire  [2:0]   rdy;
  wire  [2:0]   ov;
  wire  [2:0]   bsy;
  wire  [127:0] os [3];

  int tests = 0;
  int fails = 0;

  logic [127:0] blk_res [3];
  int           blk_lat [3];

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bsy[0])
  );
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bsy[1])
  );
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_state(in_state),
    .in_inv(in_inv), .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bsy[2])
  );

  function automatic int nstep_of(int i);
    return 4 >> i;
  endfunction

  function automatic int cpc_of(int i);
    return 1 << i;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[32*c + 24 - 8*k +: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(base[(k - row + 4) % 4], a[k]);
        r[32*c + 24 - 8*row +: 8] = b;
      end
    end
    return r;
  endfunction

  // Offers one block to all instances, then records each result and its latency,
  // counting the accepting edge as edge 1.
  task automatic run_block(input logic [127:0] st, input logic inv, input bit toggle);
    logic [2:0] got;
    int k;
    for (int i = 0; i < 3; i++) begin
      blk_res[i] = 'x;
      blk_lat[i] = -1;
    end
    @(negedge clk);
    in_state  = st;
    in_inv    = inv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = rand128();
    if (toggle) in_inv = ~inv;
    got = 3'b000;
    k = 1;
    while (got != 3'b111 && k <= 20) begin
      for (int i = 0; i < 3; i++) begin
        if (!got[i] && ov[i] === 1'b1) begin
          got[i]     = 1'b1;
          blk_res[i] = os[i];
          blk_lat[i] = k;
        end
      end
      if (got != 3'b111) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    if (got != 3'b111) begin
      tests++;
      fails++;
      $display("FAIL block_timeout out_valid_seen=%b required=111", got);
    end
    @(posedge clk);
    #1;
    $display("[TB] block inv=%0b in=%h out_c1=%h lat=%0d/%0d/%0d",
             inv, st, blk_res[0], blk_lat[0], blk_lat[1], blk_lat[2]);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_state = rand128(); in_inv = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rdy[i] !== 1'b1) begin fails++; $display("FAIL reset_in_ready c%0d got=%b required=1", cpc_of(i), rdy[i]); end
      tests++;
      if (ov[i] !== 1'b0) begin fails++; $display("FAIL reset_out_valid c%0d got=%b required=0", cpc_of(i), ov[i]); end
      tests++;
      if (bsy[i] !== 1'b0) begin fails++; $display("FAIL reset_busy c%0d got=%b required=0", cpc_of(i), bsy[i]); end
      tests++;
      if (os[i] !== 128'd0) begin fails++; $display("FAIL reset_out_state c%0d got=%h required=0", cpc_of(i), os[i]); end
    end
    $display("[TB] reset released");
  endtask

  task automatic test_forward();
    logic [127:0] exp;
    run_block({4{32'hdb135345}}, 1'b0, 1'b0);
    exp = {4{32'h8e4da1bc}};
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (blk_res[i] !== exp) begin fails++; $display("FAIL fwd_vec1 c%0d got=%h required=%h", cpc_of(i), blk_res[i], exp); end
      tests++;
      if (blk_lat[i] !== nstep_of(i) + 1) begin fails++; $display("FAIL fwd_lat1 c%0d got=%0d required=%0d", cpc_of(i), blk_lat[i], nstep_of(i) + 1); end
    end
    run_block({32'hd4d4d4d5, 32'hc6c6c6c6, 32'h01010101, 32'hf20a225c}, 1'b0, 1'b0);
    exp = {32'hd5d5d7d6, 32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d};
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (blk_res[i] !== exp) begin fails++; $display("FAIL fwd_vec2 c%0d got=%h required=%h", cpc_of(i), blk_res[i], exp); end
    end
  endtask

  task automatic test_inverse();
    logic [127:0] exp;
    run_block({4{32'h8e4da1bc}}, 1'b1, 1'b1);
    exp = {4{32'hdb135345}};
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (blk_res[i] !== exp) begin fails++; $display("FAIL inv_vec c%0d got=%h required=%h", cpc_of(i), blk_res[i], exp); end
      tests++;
      if (blk_lat[i] !== nstep_of(i) + 1) begin fails++; $display("FAIL inv_lat c%0d got=%0d required=%0d", cpc_of(i), blk_lat[i], nstep_of(i) + 1); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] st, exp;
    int k;
    st  = rand128();
    exp = ref_mix(st, 1'b0);
    @(negedge clk);
    in_state = st; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (ov !== 3'b111 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    tests++;
    if (ov !== 3'b111) begin fails++; $display("FAIL bp_wait_done got=%b required=111", ov); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      in_valid = cyc[0];
      in_state = rand128();
      in_inv   = ~in_inv;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (os[i] !== exp) begin fails++; $display("FAIL bp_hold_state c%0d cyc=%0d got=%h required=%h", cpc_of(i), cyc, os[i], exp); end
        tests++;
        if (rdy[i] !== 1'b0 || ov[i] !== 1'b1) begin
          fails++;
          $display("FAIL bp_hold_flags c%0d cyc=%0d in_ready=%b out_valid=%b required 0/1", cpc_of(i), cyc, rdy[i], ov[i]);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rdy[i] !== 1'b1 || ov[i] !== 1'b0 || bsy[i] !== 1'b0 || os[i] !== 128'd0) begin
        fails++;
        $display("FAIL bp_release c%0d in_ready=%b out_valid=%b busy=%b out_state=%h required 1/0/0/0",
                 cpc_of(i), rdy[i], ov[i], bsy[i], os[i]);
      end
    end
    $display("[TB] backpressure block in=%h out=%h", st, exp);
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] st, exp;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    in_state = rand128(); in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = seen | ov[0];
    @(posedge clk);
    #1;
    seen = seen | ov[0];
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    seen = seen | ov[0];
    tests++;
    if (bsy[0] !== 1'b0) begin fails++; $display("FAIL abort_busy c1 got=%b required=0", bsy[0]); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      seen = seen | ov[0];
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL abort_out_valid c1 got=%b required=0", seen); end
    st  = rand128();
    exp = ref_mix(st, 1'b0);
    run_block(st, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (blk_res[i] !== exp) begin fails++; $display("FAIL abort_next_block c%0d got=%h required=%h", cpc_of(i), blk_res[i], exp); end
      tests++;
      if (blk_lat[i] !== nstep_of(i) + 1) begin fails++; $display("FAIL abort_next_lat c%0d got=%0d required=%0d", cpc_of(i), blk_lat[i], nstep_of(i) + 1); end
    end
  endtask

  task automatic test_random_roundtrip();
    logic [127:0] st, fwd;
    for (int n = 0; n < 1000; n++) begin
      st  = rand128();
      fwd = ref_mix(st, 1'b0);
      run_block(st, 1'b0, n[0]);
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (blk_res[i] !== fwd) begin fails++; $display("FAIL rand_fwd c%0d n=%0d got=%h required=%h", cpc_of(i), n, blk_res[i], fwd); end
        tests++;
        if (blk_lat[i] !== nstep_of(i) + 1) begin fails++; $display("FAIL rand_fwd_lat c%0d n=%0d got=%0d required=%0d", cpc_of(i), n, blk_lat[i], nstep_of(i) + 1); end
      end
      run_block(fwd, 1'b1, n[1]);
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (blk_res[i] !== st) begin fails++; $display("FAIL rand_roundtrip c%0d n=%0d got=%h required=%h", cpc_of(i), n, blk_res[i], st); end
        tests++;
        if (blk_lat[i] !== nstep_of(i) + 1) begin fails++; $display("FAIL rand_inv_lat c%0d n=%0d got=%0d required=%0d", cpc_of(i), n, blk_lat[i], nstep_of(i) + 1); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_inv = 1'b0; out_ready = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_reset_mid_run();
    test_random_roundtrip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
